burst_rr_arbiter: RTL and testbench
===================================

Name: burst_rr_arbiter

Overview:
- Shares one registered single-entry handshake output stage among N requesters.
- Each requester presents beats with valid/ready/payload/last.
- The block grants requesters round-robin and holds the grant for a whole burst, until the beat with last=1 is accepted.
- Sits in front of shared downstream consumers (output packers, memory write ports), where bursts from different sources must not interleave.

Parameters:
- N, 4: number of requesters; legal range 1..16.
- W, 8: payload width in bits.
- IDX_W, max(1, clog2(N)): width of the source-index field; derived, not overridden.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  N  per-requester beat valid
- in_ready  out  N  per-requester beat accept
- in_payload  in  N*W  requester i occupies bits [i*W +: W]
- in_last  in  N  per-requester end-of-burst flag
- out_valid  out  1  registered output beat valid
- out_ready  in  1  downstream accept
- out_payload  out  W  registered payload
- out_last  out  1  registered last flag
- out_src  out  IDX_W  index of requester that produced the current output beat

Behaviour:
- Reset (rst=1 at edge):
  - out_valid=0, out_payload=0, out_last=0, out_src=0.
  - state=IDLE, rr_ptr=0, owner=0.
  - in_ready forced to all-zero combinationally while rst=1.
- can_load = !out_valid || out_ready. The output register accepts a new beat when empty or draining in the same cycle.
- Handshake rules:
  - A beat transfers on an input when in_valid[i] && in_ready[i].
  - At most one in_ready bit is high per cycle.
  - in_ready may depend on in_valid and out_ready.
  - in_ready[i]=0 whenever can_load=0.
- Output behaviour:
  - out_valid/out_payload/out_last/out_src are pure register outputs.
  - They hold stable while out_valid && !out_ready.
  - Latency: a beat accepted in cycle t is presented in cycle t+1.
  - Throughput: 1 beat/cycle sustained when out_ready=1 continuously.
- On a transfer from requester g:
  - out_payload<=in_payload[g], out_last<=in_last[g], out_src<=g, out_valid<=1.
- If out_ready && out_valid and there is no transfer: out_valid<=0. The other output registers keep their values.
- State IDLE:
  - If can_load and any in_valid: g = first i with in_valid[i] searching rr_ptr, rr_ptr+1, ..., wrapping mod N.
  - in_ready[g]=1; the beat transfers.
  - If in_last[g]=1: stay IDLE, rr_ptr<=(g+1) mod N (single-beat burst).
  - Else: go to LOCKED, owner<=g.
- State LOCKED:
  - in_ready[owner]=can_load; all other in_ready=0, even if their valid is high.
  - A transfer with in_last=1: go to IDLE, rr_ptr<=(owner+1) mod N.
  - A transfer with in_last=0: stay LOCKED.
  - Owner deasserting in_valid mid-burst: stay LOCKED indefinitely; no other requester is served (no timeout).
- Wrap-around: with rr_ptr=N-1, search order is N-1, 0, 1, ... When g=N-1, the next rr_ptr is 0.
- N=1: the search trivially selects 0; out_src is constant 0.
- Downstream back-pressure stalls grant; it does not change arbitration state. rr_ptr and owner only change on a transfer.
- Reset mid-burst: state returns to IDLE, and any beat held in the output register is dropped (out_valid=0). Requesters must restart the burst.
- Requester obligations (checked by assertions, not handled):
  - in_valid, once high, stays high with stable payload/last until accepted.

Decomposition:
- Shared package arb_pkg:
  - state enum (IDLE, LOCKED).
  - clog2-based IDX_W helper function.
- One natural sub-module: rr_pick (combinational).
  - Inputs: N-bit request vector and rr_ptr.
  - Outputs: found flag and IDX_W grant index.
  - Implemented by doubled-vector rotate plus priority encode.
- The top level holds:
  - the FSM, rr_ptr, owner;
  - the single-entry output register with can_load logic;
  - the payload mux.

Test Plan:
- Reset then idle, N=4, W=8: hold rst=1 for 3 cycles with in_valid=4'b1111 -> in_ready=0, out_valid=0. After release, first grant goes to requester 0 (out_src=0 at cycle +1).
- Fairness: all 4 requesters assert single-beat bursts (last=1) continuously, out_ready=1 -> out_src sequence 0,1,2,3,0,1..., one beat per cycle, payload matches source.
- Burst lock: req1 sends a 3-beat burst 0xA1,0xA2,0xA3 (last on the 3rd) while req2 stays valid -> in_ready[2]=0 until the 0xA3 transfer. Then out_src=2 is next; out_last=1 only on 0xA3.
- Back-pressure: out_ready=0 for 5 cycles with out_valid=1 and a new beat pending -> out_payload stable, all in_ready=0, rr_ptr unchanged. The next beat is accepted in the same cycle out_ready rises.
- Owner stall and wrap: req3 starts a burst (last=0), then drops in_valid for 4 cycles while req0 is valid -> no grant to req0. When req3 finishes with last=1, rr_ptr wraps to 0 and req0 is granted next.
- Reset mid-burst: assert rst during a LOCKED burst with out_valid=1 -> out_valid=0 next cycle, state IDLE, rr_ptr=0. A fresh request from req2 is granted immediately.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the burst round-robin arbiter.
package arb_pkg;

  // Arbiter FSM: IDLE searches for a new requester, LOCKED serves one burst.
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Width of a requester index; at least one bit so N=1 still has a port.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping modulo N. Rotates a doubled request vector, then priority-encodes.
module rr_pick
  import arb_pkg::*;
#(
  parameter int  N     = 4,
  localparam int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             found_o,
  output logic [IDX_W-1:0] grant_o
);

  localparam logic [IDX_W:0] N_EXT = (IDX_W + 1)'(N);

  logic [N-1:0]     rot;
  logic [IDX_W-1:0] ofs;
  logic [IDX_W:0]   sum;

  // Rotate so ptr_i lands at bit 0, find the lowest set bit, map back.
  always_comb begin
    rot     = N'({req_i, req_i} >> ptr_i);
    found_o = |rot;
    ofs     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) ofs = i[IDX_W-1:0];
    end
    sum = {1'b0, ptr_i} + {1'b0, ofs};
    if (sum >= N_EXT) sum = sum - N_EXT;
    grant_o = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/burst_rr_arbiter.sv
// N-way round-robin arbiter that holds a grant for a whole burst and feeds
// one registered single-entry output stage.
//
// Handshake: on every port a beat moves on a rising edge where valid and
// ready are both high. Requesters hold valid, payload and last steady until
// accepted. in_ready is at most one-hot, may depend on in_valid and
// out_ready, and is zero whenever the output register cannot load or rst=1.
// The out_* signals come straight from registers and hold while
// out_valid && !out_ready.
module burst_rr_arbiter
  import arb_pkg::*;
#(
  parameter int  N     = 4,
  parameter int  W     = 8,
  localparam int IDX_W = idx_w(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  input  logic [N*W-1:0]   in_payload,
  input  logic [N-1:0]     in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_payload,
  output logic             out_last,
  output logic [IDX_W-1:0] out_src,
  output state_e           dbg_state,
  output logic [IDX_W-1:0] dbg_rr_ptr,
  output logic [IDX_W-1:0] dbg_owner
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;

  logic             out_valid_q;
  logic [W-1:0]     out_payload_q;
  logic             out_last_q;
  logic [IDX_W-1:0] out_src_q;

  logic             can_load;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic             xfer;
  logic [IDX_W-1:0] sel;
  logic [W-1:0]     sel_payload;
  logic             sel_last;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    if (i == IDX_W'(N - 1)) return '0;
    return i + 1'b1;
  endfunction

  assign can_load = !out_valid_q || out_ready;

  rr_pick #(.N(N)) u_pick (
    .req_i   (in_valid),
    .ptr_i   (rr_ptr_q),
    .found_o (pick_found),
    .grant_o (pick_idx)
  );

  // Grant selection, next-state and round-robin pointer update.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    in_ready = '0;
    xfer     = 1'b0;
    sel      = '0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          sel = pick_idx;
          if (can_load && pick_found) begin
            in_ready[pick_idx] = 1'b1;
            xfer               = 1'b1;
            if (in_last[pick_idx]) begin
              rr_ptr_d = next_idx(pick_idx);
            end else begin
              state_d = LOCKED;
              owner_d = pick_idx;
            end
          end
        end
        LOCKED: begin
          // Only the owner is served; a stalled owner blocks everyone.
          sel               = owner_q;
          in_ready[owner_q] = can_load;
          if (can_load && in_valid[owner_q]) begin
            xfer = 1'b1;
            if (in_last[owner_q]) begin
              state_d  = IDLE;
              rr_ptr_d = next_idx(owner_q);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Payload mux for the selected requester.
  always_comb begin
    sel_payload = in_payload[int'(sel)*W +: W];
    sel_last    = in_last[sel];
  end

  // Arbitration state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
    end
  end

  // Single-entry output register: load on transfer, empty on drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_payload_q <= '0;
      out_last_q    <= 1'b0;
      out_src_q     <= '0;
    end else if (xfer) begin
      out_valid_q   <= 1'b1;
      out_payload_q <= sel_payload;
      out_last_q    <= sel_last;
      out_src_q     <= sel;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_payload = out_payload_q;
  assign out_last    = out_last_q;
  assign out_src     = out_src_q;
  assign dbg_state   = state_q;
  assign dbg_rr_ptr  = rr_ptr_q;
  assign dbg_owner   = owner_q;

  // Requester obligation: a waiting beat stays valid and unchanged.
  for (genvar gi = 0; gi < N; gi++) begin : g_req_chk
    a_hold : assert property (@(posedge clk) disable iff (rst)
      (in_valid[gi] && !in_ready[gi]) |=>
        (in_valid[gi] && $stable(in_payload[gi*W +: W]) && $stable(in_last[gi])));
  end

  a_onehot : assert property (@(posedge clk) $onehot0(in_ready));

endmodule

// File: tb/tb_burst_rr_arbiter.sv
// Directed bench for burst_rr_arbiter (N=4, W=8): per-requester beat queues
// drive the inputs, expected output beats go into a scoreboard queue, and a
// negedge monitor pops and compares every accepted output beat.
module tb_burst_rr_arbiter;
  import arb_pkg::*;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int IDX_W = 2;
  localparam int EW    = IDX_W + 1 + W;

  logic             clk;
  logic             rst;
  logic [N-1:0]     in_valid;
  logic [N-1:0]     in_ready;
  logic [N*W-1:0]   in_payload;
  logic [N-1:0]     in_last;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_payload;
  logic             out_last;
  logic [IDX_W-1:0] out_src;
  state_e           dbg_state;
  logic [IDX_W-1:0] dbg_rr_ptr;
  logic [IDX_W-1:0] dbg_owner;

  int checks = 0;
  int errors = 0;

  logic [EW-1:0] exp_q[$];
  logic [W:0]    rq[N][$];
  logic [N-1:0]  rdy_seen;
  logic [N-1:0]  xfer;
  logic [EW-1:0] mon_e;

  burst_rr_arbiter #(.N(N), .W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_payload  (in_payload),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_payload (out_payload),
    .out_last    (out_last),
    .out_src     (out_src),
    .dbg_state   (dbg_state),
    .dbg_rr_ptr  (dbg_rr_ptr),
    .dbg_owner   (dbg_owner)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic expect_beat(input int src, input logic last, input logic [W-1:0] pl);
    exp_q.push_back({IDX_W'(src), last, pl});
  endtask

  task automatic send(input int r, input logic last, input logic [W-1:0] pl);
    rq[r].push_back({last, pl});
  endtask

  // Present the head of every requester queue.
  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0) begin
        in_valid[i]         = 1'b1;
        in_payload[i*W +: W] = rq[i][0][W-1:0];
        in_last[i]          = rq[i][0][W];
      end else begin
        in_valid[i] = 1'b0;
      end
    end
  endtask

  // One clock: sample the handshake before the edge, retire accepted beats after.
  task automatic step();
    #1;
    rdy_seen = in_ready;
    xfer     = in_valid & in_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (xfer[i]) void'(rq[i].pop_front());
    end
    refresh();
  endtask

  // Monitor: every accepted output beat must match the scoreboard head.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got src=%0d payload=%0h, required no beat", out_src, out_payload);
      end else begin
        mon_e = exp_q.pop_front();
        chk("beat_payload", 32'(out_payload), 32'(mon_e[W-1:0]));
        chk("beat_last", 32'(out_last), 32'(mon_e[W]));
        chk("beat_src", 32'(out_src), 32'(mon_e[EW-1:W+1]));
      end
    end
  end

  initial begin
    logic [N-1:0] onehot;
    rst        = 1'b1;
    out_ready  = 1'b1;
    in_valid   = '0;
    in_payload = '0;
    in_last    = '0;

    // Reset with all requesters valid: two rounds of single-beat bursts queued.
    for (int rnd = 0; rnd < 2; rnd++)
      for (int r = 0; r < N; r++) send(r, 1'b1, W'(16 * (rnd + 1) + r));
    refresh();
    for (int k = 0; k < 3; k++) begin
      step();
      chk("reset_in_ready", 32'(rdy_seen), 32'(0));
      chk("reset_out_valid", 32'(out_valid), 32'(0));
    end
    chk("reset_payload", 32'(out_payload), 32'(0));
    chk("reset_last", 32'(out_last), 32'(0));
    chk("reset_src", 32'(out_src), 32'(0));
    chk("reset_state", 32'(dbg_state), 32'(IDLE));
    chk("reset_rr_ptr", 32'(dbg_rr_ptr), 32'(0));
    chk("reset_owner", 32'(dbg_owner), 32'(0));

    // Fairness: grants rotate 0,1,2,3,0,1,2,3 at one beat per cycle.
    for (int rnd = 0; rnd < 2; rnd++)
      for (int r = 0; r < N; r++) expect_beat(r, 1'b1, W'(16 * (rnd + 1) + r));
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      onehot = N'(1) << (k % N);
      chk("fair_ready", 32'(rdy_seen), 32'(onehot));
      chk("fair_out_valid", 32'(out_valid), 32'(1));
    end
    step();
    chk("fair_drained", 32'(out_valid), 32'(0));
    chk("fair_rr_ptr", 32'(dbg_rr_ptr), 32'(0));

    // Burst lock: req1 sends A1,A2,A3; req2 waits until A3 is taken.
    send(1, 1'b0, 8'hA1); send(1, 1'b0, 8'hA2); send(1, 1'b1, 8'hA3);
    send(2, 1'b1, 8'hB2);
    expect_beat(1, 1'b0, 8'hA1); expect_beat(1, 1'b0, 8'hA2);
    expect_beat(1, 1'b1, 8'hA3); expect_beat(2, 1'b1, 8'hB2);
    refresh();
    for (int k = 0; k < 3; k++) begin
      step();
      chk("lock_ready", 32'(rdy_seen), 32'(4'b0010));
      if (k == 0) begin
        chk("lock_state", 32'(dbg_state), 32'(LOCKED));
        chk("lock_owner", 32'(dbg_owner), 32'(1));
      end
    end
    chk("lock_end_state", 32'(dbg_state), 32'(IDLE));
    step();
    chk("lock_next_grant", 32'(rdy_seen), 32'(4'b0100));
    step();
    chk("lock_rr_ptr", 32'(dbg_rr_ptr), 32'(3));

    // Back-pressure: C0 held for 5 stalled cycles, C1 taken as out_ready rises.
    send(0, 1'b1, 8'hC0); send(1, 1'b1, 8'hC1);
    expect_beat(0, 1'b1, 8'hC0); expect_beat(1, 1'b1, 8'hC1);
    refresh();
    step();
    chk("bp_first_grant", 32'(rdy_seen), 32'(4'b0001));
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_in_ready", 32'(rdy_seen), 32'(0));
      chk("bp_payload", 32'(out_payload), 32'(8'hC0));
      chk("bp_out_valid", 32'(out_valid), 32'(1));
      chk("bp_rr_ptr", 32'(dbg_rr_ptr), 32'(1));
    end
    out_ready = 1'b1;
    step();
    chk("bp_resume_grant", 32'(rdy_seen), 32'(4'b0010));
    step();

    // Owner stall and wrap: req3 pauses mid-burst, req0 must wait.
    send(3, 1'b0, 8'hD0); send(0, 1'b1, 8'hE0);
    expect_beat(3, 1'b0, 8'hD0); expect_beat(3, 1'b1, 8'hD1); expect_beat(0, 1'b1, 8'hE0);
    refresh();
    step();
    chk("stall_start_grant", 32'(rdy_seen), 32'(4'b1000));
    for (int k = 0; k < 4; k++) begin
      step();
      chk("stall_no_req0", 32'(rdy_seen[0]), 32'(0));
      chk("stall_state", 32'(dbg_state), 32'(LOCKED));
    end
    send(3, 1'b1, 8'hD1);
    refresh();
    step();
    chk("stall_finish_grant", 32'(rdy_seen), 32'(4'b1000));
    chk("wrap_rr_ptr", 32'(dbg_rr_ptr), 32'(0));
    chk("wrap_state", 32'(dbg_state), 32'(IDLE));
    step();
    chk("wrap_grant_req0", 32'(rdy_seen), 32'(4'b0001));
    step();

    // Reset mid-burst: held beat F0 is dropped, req2 is granted right after.
    send(1, 1'b0, 8'hF0); send(1, 1'b0, 8'hF1); send(1, 1'b1, 8'hF2);
    refresh();
    step();
    chk("mid_start_grant", 32'(rdy_seen), 32'(4'b0010));
    out_ready = 1'b0;
    step();
    chk("mid_stall_ready", 32'(rdy_seen), 32'(0));
    chk("mid_held_valid", 32'(out_valid), 32'(1));
    rst = 1'b1;
    step();
    chk("mid_rst_ready", 32'(rdy_seen), 32'(0));
    chk("mid_rst_out_valid", 32'(out_valid), 32'(0));
    chk("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    chk("mid_rst_rr_ptr", 32'(dbg_rr_ptr), 32'(0));
    rq[1].delete();
    refresh();
    step();
    rst       = 1'b0;
    out_ready = 1'b1;
    send(2, 1'b1, 8'h5A);
    expect_beat(2, 1'b1, 8'h5A);
    refresh();
    step();
    chk("post_rst_grant", 32'(rdy_seen), 32'(4'b0100));
    step();
    step();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
